// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect request and BPU redirect channel bundle
interface fetch_redirect_ctrl_if #(
    parameter int EPOCH_W = 2,
    parameter int RAS_W   = 3
);
    logic               be_redirect_i;
    logic [31:0]        be_pc_i;
    logic [31:0]        be_target_i;
    logic [RAS_W-1:0]   be_ras_ptr_i;
    logic               pc_redirect_i;
    logic [31:0]        pc_pc_i;
    logic [31:0]        pc_target_i;
    logic [RAS_W-1:0]   pc_ras_ptr_i;
    logic [EPOCH_W-1:0] pc_epoch_i;
    logic               bpu_ready_i;
    logic               redirect_o;
    logic [31:0]        redirect_pc_o;
    logic [31:0]        redirect_target_o;
    logic [RAS_W-1:0]   redirect_ras_ptr_o;
    logic               redirect_src_o;

    modport master (
        output be_redirect_i, be_pc_i, be_target_i, be_ras_ptr_i,
        output pc_redirect_i, pc_pc_i, pc_target_i, pc_ras_ptr_i, pc_epoch_i,
        output bpu_ready_i,
        input  redirect_o, redirect_pc_o, redirect_target_o, redirect_ras_ptr_o, redirect_src_o
    );

    modport slave (
        input  be_redirect_i, be_pc_i, be_target_i, be_ras_ptr_i,
        input  pc_redirect_i, pc_pc_i, pc_target_i, pc_ras_ptr_i, pc_epoch_i,
        input  bpu_ready_i,
        output redirect_o, redirect_pc_o, redirect_target_o, redirect_ras_ptr_o, redirect_src_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - arbitrates backend and pre-check redirects into the BPU
module fetch_redirect_ctrl #(
    parameter int EPOCH_W      = 2,
    parameter int RAS_W        = 3,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_redirect_ctrl_if.slave rif,
    output logic                flush_fetch_o,
    output logic [EPOCH_W-1:0]  epoch_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    drop_cnt_o
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        target_q, target_d;
    logic [RAS_W-1:0]   ras_q, ras_d;
    logic               src_q, src_d;
    logic               flush_q, flush_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic pc_eligible;
    logic pc_accept;
    logic handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            redirect_q <= 1'b0;
            pc_q       <= '0;
            target_q   <= '0;
            ras_q      <= '0;
            src_q      <= 1'b0;
            flush_q    <= 1'b0;
            epoch_q    <= '0;
            drain_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            ras_q      <= ras_d;
            src_q      <= src_d;
            flush_q    <= flush_d;
            epoch_q    <= epoch_d;
            drain_q    <= drain_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        redirect_d = redirect_q;
        pc_d       = pc_q;
        target_d   = target_q;
        ras_d      = ras_q;
        src_d      = src_q;
        flush_d    = 1'b0;
        epoch_d    = epoch_q;
        drain_d    = drain_q;
        drop_d     = drop_q;

        // Stale packets carry an old epoch; only the current epoch may redirect.
        pc_eligible = rif.pc_redirect_i && (rif.pc_epoch_i == epoch_q);
        pc_accept   = (state_q == IDLE) && !rif.be_redirect_i && pc_eligible;
        handshake   = redirect_q && rif.bpu_ready_i;

        case (state_q)
            IDLE: ;
            PEND: begin
                if (handshake) begin
                    redirect_d = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A backend redirect overrides whatever is pending or draining.
        if (rif.be_redirect_i) begin
            state_d    = PEND;
            redirect_d = 1'b1;
            pc_d       = rif.be_pc_i;
            target_d   = rif.be_target_i;
            ras_d      = rif.be_ras_ptr_i;
            src_d      = 1'b1;
            flush_d    = 1'b1;
            epoch_d    = epoch_q + 1'b1;
        end else if (pc_accept) begin
            state_d    = PEND;
            redirect_d = 1'b1;
            pc_d       = rif.pc_pc_i;
            target_d   = rif.pc_target_i;
            ras_d      = rif.pc_ras_ptr_i;
            src_d      = 1'b0;
            flush_d    = 1'b1;
            epoch_d    = epoch_q + 1'b1;
        end

        if (rif.pc_redirect_i && !pc_accept && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    assign rif.redirect_o         = redirect_q;
    assign rif.redirect_pc_o      = pc_q;
    assign rif.redirect_target_o  = target_q;
    assign rif.redirect_ras_ptr_o = ras_q;
    assign rif.redirect_src_o     = src_q;
    assign flush_fetch_o          = flush_q;
    assign epoch_o                = epoch_q;
    assign busy_o                 = (state_q != IDLE);
    assign drop_cnt_o             = drop_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    logic        clk;
    logic        rst;
    logic        flush_fetch;
    logic [1:0]  epoch;
    logic        busy;
    logic [15:0] drop_cnt;
    int          errors;
    int          checks;

    fetch_redirect_ctrl_if #(.EPOCH_W(2), .RAS_W(3)) rif ();

    fetch_redirect_ctrl #(
        .EPOCH_W(2), .RAS_W(3), .DRAIN_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rif(rif),
        .flush_fetch_o(flush_fetch),
        .epoch_o(epoch),
        .busy_o(busy),
        .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rif.be_redirect_i = 1'b0;
        rif.be_pc_i       = '0;
        rif.be_target_i   = '0;
        rif.be_ras_ptr_i  = '0;
        rif.pc_redirect_i = 1'b0;
        rif.pc_pc_i       = '0;
        rif.pc_target_i   = '0;
        rif.pc_ras_ptr_i  = '0;
        rif.pc_epoch_i    = '0;
        rif.bpu_ready_i   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({rif.redirect_o, flush_fetch, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000", {rif.redirect_o, flush_fetch, busy});
        end
        checks++;
        if (epoch !== 2'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: epoch=%0d drop=%0d want 0 0", epoch, drop_cnt);
        end
    endtask

    task automatic test_precheck_basic();
        rif.pc_redirect_i = 1'b1;
        rif.pc_epoch_i    = 2'd0;
        rif.pc_pc_i       = 32'h1C00_0010;
        rif.pc_target_i   = 32'h1C00_0014;
        rif.pc_ras_ptr_i  = 3'd3;
        rif.bpu_ready_i   = 1'b1;
        step();
        rif.pc_redirect_i = 1'b0;
        checks++;
        if ({rif.redirect_o, rif.redirect_src_o, flush_fetch, busy} !== 4'b1011) begin
            errors++;
            $display("FAIL pc_basic_ctrl: got %b want 1011",
                     {rif.redirect_o, rif.redirect_src_o, flush_fetch, busy});
        end
        checks++;
        if (rif.redirect_pc_o !== 32'h1C00_0010 || rif.redirect_target_o !== 32'h1C00_0014 ||
            rif.redirect_ras_ptr_o !== 3'd3) begin
            errors++;
            $display("FAIL pc_basic_payload: got %h %h %0d want 1c000010 1c000014 3",
                     rif.redirect_pc_o, rif.redirect_target_o, rif.redirect_ras_ptr_o);
        end
        checks++;
        if (epoch !== 2'd1) begin
            errors++;
            $display("FAIL pc_basic_epoch: got %0d want 1", epoch);
        end
        step();
        checks++;
        if ({rif.redirect_o, flush_fetch, busy} !== 3'b001) begin
            errors++;
            $display("FAIL pc_basic_drain1: got %b want 001", {rif.redirect_o, flush_fetch, busy});
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pc_basic_drain2: busy got %b want 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pc_basic_idle: busy=%b drop=%0d want 0 0", busy, drop_cnt);
        end
    endtask

    task automatic test_stall();
        int flushes;
        flushes = 0;
        rif.pc_redirect_i = 1'b1;
        rif.pc_epoch_i    = 2'd1;
        rif.pc_pc_i       = 32'h1C00_0020;
        rif.pc_target_i   = 32'h1C00_0024;
        rif.pc_ras_ptr_i  = 3'd5;
        rif.bpu_ready_i   = 1'b0;
        step();
        rif.pc_redirect_i = 1'b0;
        rif.pc_pc_i       = 32'hDEAD_BEEF;
        if (flush_fetch === 1'b1) flushes++;
        checks++;
        if (epoch !== 2'd2) begin
            errors++;
            $display("FAIL stall_epoch: got %0d want 2", epoch);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (flush_fetch === 1'b1) flushes++;
            checks++;
            if (rif.redirect_o !== 1'b1 || rif.redirect_pc_o !== 32'h1C00_0020 ||
                rif.redirect_target_o !== 32'h1C00_0024 || rif.redirect_ras_ptr_o !== 3'd5) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h tgt=%h ras=%0d want 1 1c000020 1c000024 5",
                         i, rif.redirect_o, rif.redirect_pc_o, rif.redirect_target_o,
                         rif.redirect_ras_ptr_o);
            end
        end
        rif.bpu_ready_i = 1'b1;
        step();
        if (flush_fetch === 1'b1) flushes++;
        checks++;
        if (rif.redirect_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_handshake: redirect got %b want 0", rif.redirect_o);
        end
        checks++;
        if (flushes != 1) begin
            errors++;
            $display("FAIL stall_flush_count: got %0d want 1", flushes);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_be_in_pend();
        rif.pc_redirect_i = 1'b1;
        rif.pc_epoch_i    = 2'd2;
        rif.pc_pc_i       = 32'h1C00_0030;
        rif.pc_target_i   = 32'h1C00_0034;
        rif.pc_ras_ptr_i  = 3'd1;
        rif.bpu_ready_i   = 1'b0;
        step();
        rif.pc_redirect_i = 1'b0;
        checks++;
        if (rif.redirect_src_o !== 1'b0 || epoch !== 2'd3 || flush_fetch !== 1'b1) begin
            errors++;
            $display("FAIL bepend_first: src=%b epoch=%0d flush=%b want 0 3 1",
                     rif.redirect_src_o, epoch, flush_fetch);
        end
        rif.be_redirect_i = 1'b1;
        rif.be_pc_i       = 32'h1C00_00F0;
        rif.be_target_i   = 32'h1C00_0100;
        rif.be_ras_ptr_i  = 3'd6;
        step();
        rif.be_redirect_i = 1'b0;
        checks++;
        if ({rif.redirect_o, rif.redirect_src_o, flush_fetch} !== 3'b111 || epoch !== 2'd0) begin
            errors++;
            $display("FAIL bepend_ctrl: v/src/flush=%b epoch=%0d want 111 0",
                     {rif.redirect_o, rif.redirect_src_o, flush_fetch}, epoch);
        end
        checks++;
        if (rif.redirect_pc_o !== 32'h1C00_00F0 || rif.redirect_target_o !== 32'h1C00_0100 ||
            rif.redirect_ras_ptr_o !== 3'd6) begin
            errors++;
            $display("FAIL bepend_payload: got %h %h %0d want 1c0000f0 1c000100 6",
                     rif.redirect_pc_o, rif.redirect_target_o, rif.redirect_ras_ptr_o);
        end
        rif.bpu_ready_i = 1'b1;
        step();
        checks++;
        if (rif.redirect_o !== 1'b0 || flush_fetch !== 1'b0) begin
            errors++;
            $display("FAIL bepend_done: v=%b flush=%b want 0 0", rif.redirect_o, flush_fetch);
        end
        step();
        step();
    endtask

    task automatic test_simultaneous();
        rif.bpu_ready_i   = 1'b1;
        rif.be_redirect_i = 1'b1;
        rif.be_pc_i       = 32'h1C00_0200;
        rif.be_target_i   = 32'h1C00_0300;
        rif.be_ras_ptr_i  = 3'd2;
        rif.pc_redirect_i = 1'b1;
        rif.pc_epoch_i    = 2'd0;
        rif.pc_pc_i       = 32'h1C00_0040;
        step();
        rif.be_redirect_i = 1'b0;
        rif.pc_redirect_i = 1'b0;
        checks++;
        if (rif.redirect_src_o !== 1'b1 || rif.redirect_pc_o !== 32'h1C00_0200 ||
            rif.redirect_target_o !== 32'h1C00_0300) begin
            errors++;
            $display("FAIL simul_winner: src=%b pc=%h tgt=%h want 1 1c000200 1c000300",
                     rif.redirect_src_o, rif.redirect_pc_o, rif.redirect_target_o);
        end
        checks++;
        if (drop_cnt !== 16'd1 || epoch !== 2'd1) begin
            errors++;
            $display("FAIL simul_drop: drop=%0d epoch=%0d want 1 1", drop_cnt, epoch);
        end
        step();
        step();
        step();
    endtask

    task automatic test_drops();
        rif.pc_redirect_i = 1'b1;
        rif.pc_epoch_i    = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rif.redirect_o !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'(2 + i)) begin
                errors++;
                $display("FAIL stale_drop[%0d]: v=%b busy=%b drop=%0d want 0 0 %0d",
                         i, rif.redirect_o, busy, drop_cnt, 2 + i);
            end
        end
        rif.pc_epoch_i = 2'd1;
        rif.bpu_ready_i = 1'b1;
        step();
        checks++;
        if (rif.redirect_o !== 1'b1 || epoch !== 2'd2 || drop_cnt !== 16'd4) begin
            errors++;
            $display("FAIL drop_accept: v=%b epoch=%0d drop=%0d want 1 2 4",
                     rif.redirect_o, epoch, drop_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rif.redirect_o !== 1'b0 || drop_cnt !== 16'(5 + i)) begin
                errors++;
                $display("FAIL busy_drop[%0d]: v=%b drop=%0d want 0 %0d",
                         i, rif.redirect_o, drop_cnt, 5 + i);
            end
        end
        rif.pc_redirect_i = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        rif.bpu_ready_i   = 1'b1;
        rif.be_redirect_i = 1'b1;
        rif.be_pc_i       = 32'h1C00_0400;
        rif.be_target_i   = 32'h1C00_0500;
        step();
        rif.be_pc_i       = 32'h1C00_0600;
        rif.be_target_i   = 32'h1C00_0700;
        checks++;
        if (flush_fetch !== 1'b1 || epoch !== 2'd3) begin
            errors++;
            $display("FAIL b2b_first: flush=%b epoch=%0d want 1 3", flush_fetch, epoch);
        end
        step();
        rif.be_redirect_i = 1'b0;
        checks++;
        if (flush_fetch !== 1'b1 || epoch !== 2'd0 || rif.redirect_pc_o !== 32'h1C00_0600) begin
            errors++;
            $display("FAIL b2b_second: flush=%b epoch=%0d pc=%h want 1 0 1c000600",
                     flush_fetch, epoch, rif.redirect_pc_o);
        end
        step();
        rif.be_redirect_i = 1'b1;
        rif.be_pc_i       = 32'h1C00_0800;
        checks++;
        if (rif.redirect_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: v=%b busy=%b want 0 1", rif.redirect_o, busy);
        end
        step();
        rif.be_redirect_i = 1'b0;
        checks++;
        if ({rif.redirect_o, flush_fetch} !== 2'b11 || epoch !== 2'd1 ||
            rif.redirect_pc_o !== 32'h1C00_0800) begin
            errors++;
            $display("FAIL drain_abort: v/flush=%b epoch=%0d pc=%h want 11 1 1c000800",
                     {rif.redirect_o, flush_fetch}, epoch, rif.redirect_pc_o);
        end
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_saturate();
        rif.pc_redirect_i = 1'b1;
        rif.pc_epoch_i    = 2'd3;
        for (int i = 0; i < 65535 - 7 - 1; i++) step();
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_near: got %h want fffe", drop_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (drop_cnt !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_hold[%0d]: got %h want ffff", i, drop_cnt);
            end
        end
        rif.pc_redirect_i = 1'b0;
    endtask

    task automatic test_reset_pend();
        rif.bpu_ready_i   = 1'b0;
        rif.be_redirect_i = 1'b1;
        rif.be_pc_i       = 32'h1C00_0900;
        rif.be_target_i   = 32'h1C00_0A00;
        rif.be_ras_ptr_i  = 3'd7;
        step();
        rif.be_redirect_i = 1'b0;
        checks++;
        if (rif.redirect_o !== 1'b1) begin
            errors++;
            $display("FAIL rstpend_setup: v got %b want 1", rif.redirect_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({rif.redirect_o, rif.redirect_src_o, flush_fetch, busy} !== 4'b0000 ||
            rif.redirect_pc_o !== 32'd0 || rif.redirect_target_o !== 32'd0 ||
            rif.redirect_ras_ptr_o !== 3'd0 || epoch !== 2'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstpend_clear: ctrl=%b pc=%h tgt=%h ras=%0d epoch=%0d drop=%0d want all 0",
                     {rif.redirect_o, rif.redirect_src_o, flush_fetch, busy}, rif.redirect_pc_o,
                     rif.redirect_target_o, rif.redirect_ras_ptr_o, epoch, drop_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_precheck_basic();
        test_stall();
        test_be_in_pend();
        test_simultaneous();
        test_drops();
        test_back_to_back();
        test_saturate();
        test_reset_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
